// File: rtl/auto_pq_gen2_if.sv
// Control and display bundle for the auto_pq_gen2 self-driving priority queue.
// The slave side is the queue; the master side is whoever issues start and watches the results.
interface auto_pq_gen2_if #(
  parameter int KW    = 4,
  parameter int DW    = 4,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              start;
  logic              max_mode;
  logic [KW+DW-1:0]  seed;
  logic [KW-1:0]     key_out;
  logic [DW-1:0]     data_out;
  logic              out_valid;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              sigIDLE;
  logic              sigSTART;
  logic              sigADD;
  logic              sigREMOVE;
  logic              sigDISPLAY;

  modport master (
    output start, max_mode, seed,
    input  key_out, data_out, out_valid, count, full, empty,
           sigIDLE, sigSTART, sigADD, sigREMOVE, sigDISPLAY
  );

  modport slave (
    input  start, max_mode, seed,
    output key_out, data_out, out_valid, count, full, empty,
           sigIDLE, sigSTART, sigADD, sigREMOVE, sigDISPLAY
  );
endinterface

// File: rtl/auto_pq_gen2.sv
// Self-driving sorted priority queue: fills DEPTH entries from a Galois LFSR, then
// drains them in min- or max-first order, holding each popped entry for DISP_CYC cycles.
module auto_pq_gen2 #(
  parameter int                 KW       = 4,
  parameter int                 DW       = 4,
  parameter int                 DEPTH    = 8,
  parameter int                 DISP_CYC = 4,
  parameter logic [KW+DW-1:0]   POLY     = 8'hB8
) (
  input  logic            clk,
  input  logic            rst,
  auto_pq_gen2_if.slave   pq
);
  localparam int W   = KW + DW;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int DCW = $clog2(DISP_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADD, S_REMOVE, S_DISPLAY
  } state_t;

  state_t          state, state_n;
  logic [W-1:0]    lfsr, lfsr_n;
  logic [W-1:0]    q     [DEPTH];
  logic [W-1:0]    q_n   [DEPTH];
  logic [W-1:0]    q_sh  [DEPTH];
  logic [CW-1:0]   cnt;
  logic [DCW-1:0]  disp_cnt;
  logic            mode;
  logic [KW-1:0]   key_r;
  logic [DW-1:0]   data_r;
  logic [DEPTH-1:0] beat;
  logic [DEPTH-1:0] beat_prev;

  // a strictly outranks b under the latched direction; equal keys never outrank,
  // which is what keeps ties in arrival order
  function automatic logic outranks(input logic [KW-1:0] a, input logic [KW-1:0] b,
                                    input logic mx);
    return mx ? (a > b) : (a < b);
  endfunction

  assign lfsr_n = lfsr[0] ? ((lfsr >> 1) ^ POLY) : (lfsr >> 1);

  // beat is monotonic (0..0 1..1) because the array is sorted and empty slots count as beaten,
  // so the insert slot is simply its first set bit
  always_comb begin
    beat = '0;
    for (int i = 0; i < DEPTH; i++)
      beat[i] = (CW'(i) < cnt) ? outranks(lfsr[W-1:DW], q[i][W-1:DW], mode) : 1'b1;
  end
  assign beat_prev = {beat[DEPTH-2:0], 1'b0};

  always_comb begin
    q_sh[0] = '0;
    for (int i = 1; i < DEPTH; i++) q_sh[i] = q[i-1];
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) q_n[i] = q[i];
    case (state)
      S_START: begin
        for (int i = 0; i < DEPTH; i++) q_n[i] = '0;
      end
      S_ADD: begin
        for (int i = 0; i < DEPTH; i++) begin
          if (beat[i] && !beat_prev[i]) q_n[i] = lfsr;
          else if (beat[i])             q_n[i] = q_sh[i];
        end
      end
      S_REMOVE: begin
        for (int i = 0; i < DEPTH - 1; i++) q_n[i] = q[i+1];
        q_n[DEPTH-1] = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (pq.start) state_n = S_START;
      S_START:   state_n = S_ADD;
      S_ADD:     if (cnt == CW'(DEPTH - 1)) state_n = S_REMOVE;
      S_REMOVE:  state_n = S_DISPLAY;
      S_DISPLAY: if (disp_cnt == DCW'(DISP_CYC - 1))
                   state_n = (cnt == '0) ? S_IDLE : S_REMOVE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      lfsr     <= '0;
      cnt      <= '0;
      disp_cnt <= '0;
      mode     <= 1'b0;
      key_r    <= '0;
      data_r   <= '0;
    end else begin
      state <= state_n;
      case (state)
        S_START: begin
          lfsr     <= (pq.seed == '0) ? '1 : pq.seed;
          cnt      <= '0;
          disp_cnt <= '0;
          mode     <= pq.max_mode;
        end
        S_ADD: begin
          lfsr <= lfsr_n;
          cnt  <= cnt + CW'(1);
        end
        S_REMOVE: begin
          key_r    <= q[0][W-1:DW];
          data_r   <= q[0][DW-1:0];
          cnt      <= cnt - CW'(1);
          disp_cnt <= '0;
        end
        S_DISPLAY: disp_cnt <= disp_cnt + DCW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      q[i] <= rst ? '0 : q_n[i];
  end

  assign pq.key_out    = key_r;
  assign pq.data_out   = data_r;
  assign pq.out_valid  = (state == S_DISPLAY);
  assign pq.count      = cnt;
  assign pq.full       = (cnt == CW'(DEPTH));
  assign pq.empty      = (cnt == '0);
  assign pq.sigIDLE    = (state == S_IDLE);
  assign pq.sigSTART   = (state == S_START);
  assign pq.sigADD     = (state == S_ADD);
  assign pq.sigREMOVE  = (state == S_REMOVE);
  assign pq.sigDISPLAY = (state == S_DISPLAY);
endmodule

// File: tb/tb_auto_pq_gen2.sv
// Scoreboard bench for auto_pq_gen2 at default parameters: expected pop order is queued
// by the stimulus, and a monitor checks every entry the DUT presents on out_valid.
`timescale 1ns/1ps
module tb_auto_pq_gen2;
  localparam int DISP_CYC = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  auto_pq_gen2_if #(.KW(4), .DW(4), .DEPTH(8)) bus ();

  auto_pq_gen2 #(.KW(4), .DW(4), .DEPTH(8), .DISP_CYC(DISP_CYC), .POLY(8'hB8)) dut (
    .clk (clk),
    .rst (rst),
    .pq  (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  // seed 01 inserts 01,B8,5C,2E,17,B3,E1,C8; seed 00 inserts FF,C7,DB,D5,D2,69,8C,46
  logic [7:0] min_s1 [8] = '{8'h01, 8'h17, 8'h2E, 8'h5C, 8'hB8, 8'hB3, 8'hC8, 8'hE1};
  logic [7:0] max_s1 [8] = '{8'hE1, 8'hC8, 8'hB8, 8'hB3, 8'h5C, 8'h2E, 8'h17, 8'h01};
  logic [7:0] min_s0 [8] = '{8'h46, 8'h69, 8'h8C, 8'hC7, 8'hDB, 8'hD5, 8'hD2, 8'hFF};

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // monitor: pop on each rising out_valid, then check hold stability and display length
  logic prev_v = 1'b0;
  int   hold   = 0;
  logic [7:0] cur = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
      hold   = 0;
    end else begin
      if (bus.out_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_output: got %0h, expected none", {bus.key_out, bus.data_out});
        end else begin
          cur = exp_q.pop_front();
          chk("pop_order", {bus.key_out, bus.data_out}, cur);
        end
        hold = 1;
      end else if (bus.out_valid) begin
        hold++;
        chk("hold_stable", {bus.key_out, bus.data_out}, cur);
      end else if (prev_v) begin
        chk("disp_len", hold, DISP_CYC);
      end
      prev_v = bus.out_valid;
    end
  end

  task automatic push_tab(input logic [7:0] t [8], input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(t[i]);
  endtask

  task automatic begin_run(input bit keep_start);
    bus.start = 1'b1;
    @(negedge clk);
    chk("enter_start", bus.sigSTART, 1);
    if (!keep_start) bus.start = 1'b0;
  endtask

  // entered at the negedge where sigSTART is high; returns at the first IDLE negedge
  task automatic run(input bit toggle_max, input bit drop_start);
    int idx = 0;
    int full_idx = -1;
    int peak = 0;
    while (!bus.sigIDLE && idx < 200) begin
      if (bus.full && full_idx < 0) full_idx = idx;
      if (int'(bus.count) > peak) peak = int'(bus.count);
      if (idx == 4) chk("count_mid_add", bus.count, 3);
      if (toggle_max && idx == 3) bus.max_mode = ~bus.max_mode;
      if (drop_start && bus.sigDISPLAY) bus.start = 1'b0;
      idx++;
      @(negedge clk);
    end
    chk("run_len", idx, 49);
    chk("full_at", full_idx, 9);
    chk("peak_count", peak, 8);
    chk("empty_end", bus.empty, 1);
  endtask

  task automatic chk_reset_state();
    chk("rst_sig", {bus.sigIDLE, bus.sigSTART, bus.sigADD, bus.sigREMOVE, bus.sigDISPLAY}, 5'b10000);
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_out", {bus.key_out, bus.data_out}, 0);
  endtask

  initial begin
    int nrem;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.max_mode = 1'b0;
    bus.seed = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_state();
    rst = 1'b0;
    @(negedge clk);

    // min mode, start held: back-to-back runs, second one drops start mid-DISPLAY
    bus.seed = 8'h01;
    push_tab(min_s1, 8);
    begin_run(1'b1);
    run(1'b0, 1'b0);
    chk("idle_between", bus.sigIDLE, 1);
    push_tab(min_s1, 8);
    @(negedge clk);
    chk("restart", bus.sigSTART, 1);
    run(1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("stay_idle", bus.sigIDLE, 1);
    chk("hold_last", {bus.key_out, bus.data_out}, 8'hE1);

    // max mode; flipping max_mode during ADD must not matter
    bus.max_mode = 1'b1;
    push_tab(max_s1, 8);
    begin_run(1'b0);
    run(1'b1, 1'b0);

    // zero seed becomes all-ones
    bus.seed = 8'h00;
    bus.max_mode = 1'b0;
    push_tab(min_s0, 8);
    begin_run(1'b0);
    run(1'b0, 1'b0);

    // reset at the third REMOVE: only two entries are ever displayed
    bus.seed = 8'h01;
    push_tab(min_s1, 2);
    begin_run(1'b0);
    nrem = 0;
    for (int c = 0; c < 200; c++) begin
      if (bus.sigREMOVE) nrem++;
      if (nrem == 3) break;
      @(negedge clk);
    end
    chk("third_remove", nrem, 3);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_rst", bus.sigIDLE, 1);

    chk("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
